reg_rename_file: RTL

- Architectural register file plus rename-tag table for the out-of-order core; the responder on the ROB's rename/commit interface.
- On issue, the ROB announces a new destination (`upd_*`). This block marks that register busy and tags it with the ROB entry.
- On commit, the ROB writes the final value (`write_*`). This block clears busy only if the tag still matches.
- The decoder reads rs1/rs2 here: it gets either the value (ready) or the ROB tag to look up in the ROB.

---
 rtl/reg_rename_file_if.sv | 35 +++
 rtl/reg_rename_file.sv | 106 ++++++++++
 2 files changed

// File: rtl/reg_rename_file_if.sv
// rtl/reg_rename_file_if.sv - ROB rename/commit and decoder read bundle for reg_rename_file
interface reg_rename_file_if #(
  parameter int XLEN = 32,
  parameter int RB_W = 4
);
  logic            rdy;
  logic            jp_wrong;
  logic            upd_flag;
  logic [RB_W-1:0] upd_idx;
  logic [4:0]      upd_rd;
  logic            write_flag;
  logic [RB_W-1:0] write_idx;
  logic [4:0]      write_rd;
  logic [XLEN-1:0] new_val;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [RB_W-1:0] rs1_idx;
  logic [RB_W-1:0] rs2_idx;

  modport master (
    output rdy, jp_wrong, upd_flag, upd_idx, upd_rd,
    output write_flag, write_idx, write_rd, new_val, rs1, rs2,
    input  rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_idx, rs2_idx
  );

  modport slave (
    input  rdy, jp_wrong, upd_flag, upd_idx, upd_rd,
    input  write_flag, write_idx, write_rd, new_val, rs1, rs2,
    output rs1_busy, rs2_busy, rs1_val, rs2_val, rs1_idx, rs2_idx
  );
endinterface

// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with rename tags; optional commit bypass via REGFILE_BYPASS_EN
module reg_rename_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RB_W = 4
) (
  input logic              clk,
  input logic              rst,
  reg_rename_file_if.slave bus
);

  logic [XLEN-1:0] r_val [NREG];
  logic [NREG-1:0] r_busy;
  logic [RB_W-1:0] r_tag [NREG];

  logic            w_commit;
  logic            w_rename;
  logic            w_retire;
  logic            w_byp1;
  logic            w_byp2;
  logic            w_rs1_busy;
  logic            w_rs2_busy;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [RB_W-1:0] w_rs1_idx;
  logic [RB_W-1:0] w_rs2_idx;

  // x0 is hardwired, so requests targeting it are dropped here.
  assign w_commit = bus.write_flag && (bus.write_rd != 5'd0);
  assign w_rename = bus.upd_flag && (bus.upd_rd != 5'd0);
  // Only the producer that still owns the register may release it.
  assign w_retire = w_commit && r_busy[bus.write_rd] &&
                    (r_tag[bus.write_rd] == bus.write_idx);

`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = w_retire && (bus.write_rd == bus.rs1);
  assign w_byp2 = w_retire && (bus.write_rd == bus.rs2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  // State update: value on commit, busy/tag on rename/retire, full tag wipe on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (bus.rdy) begin
      if (w_commit) r_val[bus.write_rd] <= bus.new_val;
      if (bus.jp_wrong) begin
        r_busy <= '0;
        for (int i = 0; i < NREG; i++) r_tag[i] <= '0;
      end else begin
        if (w_retire) r_busy[bus.write_rd] <= 1'b0;
        // Rename is assigned last so it wins over a same-register retire.
        if (w_rename) begin
          r_busy[bus.upd_rd] <= 1'b1;
          r_tag[bus.upd_rd]  <= bus.upd_idx;
        end
      end
    end
  end

  // Read port 1: x0, then commit bypass, then stored state with tag masked when idle.
  always_comb begin
    w_rs1_busy = 1'b0;
    w_rs1_val  = '0;
    w_rs1_idx  = '0;
    if (bus.rs1 != 5'd0) begin
      if (w_byp1) begin
        w_rs1_val = bus.new_val;
      end else begin
        w_rs1_busy = r_busy[bus.rs1];
        w_rs1_val  = r_val[bus.rs1];
        w_rs1_idx  = r_busy[bus.rs1] ? r_tag[bus.rs1] : '0;
      end
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    w_rs2_busy = 1'b0;
    w_rs2_val  = '0;
    w_rs2_idx  = '0;
    if (bus.rs2 != 5'd0) begin
      if (w_byp2) begin
        w_rs2_val = bus.new_val;
      end else begin
        w_rs2_busy = r_busy[bus.rs2];
        w_rs2_val  = r_val[bus.rs2];
        w_rs2_idx  = r_busy[bus.rs2] ? r_tag[bus.rs2] : '0;
      end
    end
  end

  assign bus.rs1_busy = w_rs1_busy;
  assign bus.rs1_val  = w_rs1_val;
  assign bus.rs1_idx  = w_rs1_idx;
  assign bus.rs2_busy = w_rs2_busy;
  assign bus.rs2_val  = w_rs2_val;
  assign bus.rs2_idx  = w_rs2_idx;

endmodule
